// File: rtl/uart_tx_buffered_if.sv
// uart_tx_buffered_if: byte-write port, transmit enable, serial line and status
// flags of the buffered UART transmitter.
// master = the logic feeding bytes in; slave = the transmitter itself.
`timescale 1ns/1ps

interface uart_tx_buffered_if;
    logic       en;               // transmit enable
    logic       tx_write;         // one-cycle write strobe
    logic [7:0] tx_send_data;     // byte captured when tx_write=1
    logic       tx_pin_out;       // serial line, idle high
    logic       tx_buf_not_full;  // FIFO can take another byte
    logic       tx_buf_empty;     // FIFO holds no bytes
    logic       tx_busy;          // a frame is on the line
    logic       tx_overflow;      // sticky: a write hit a full FIFO

    modport master (
        output en,
        output tx_write,
        output tx_send_data,
        input  tx_pin_out,
        input  tx_buf_not_full,
        input  tx_buf_empty,
        input  tx_busy,
        input  tx_overflow
    );

    modport slave (
        input  en,
        input  tx_write,
        input  tx_send_data,
        output tx_pin_out,
        output tx_buf_not_full,
        output tx_buf_empty,
        output tx_busy,
        output tx_overflow
    );
endinterface

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: buffered 8N1 UART transmitter.
// Bytes are pushed into a 2**FIFO_AW deep FIFO by a single-cycle strobe and
// sent LSB-first at CLK_FREQ/BAUD clocks per bit. Queued bytes are sent
// back-to-back: the end of a stop bit pops the next byte straight into START.
// The serial pin is a register that follows the FSM's line value one cycle
// later, so a write at edge N shows a start bit after edge N+2.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (11 bit periods per frame).
`timescale 1ns/1ps

module uart_tx_buffered #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 9600,
    parameter int FIFO_AW  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_tx_buffered_if.slave  bus
);

    // Bit period in clocks; must be at least 2.
    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] COUNT_FULL = (FIFO_AW + 1)'(DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd4
    } state_t;
`endif

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_overflow;

    logic               w_full;
    logic               w_empty;
    logic               w_wr_accept;
    logic               w_pop;

    // ------------------------------------------------------------------
    // Serialiser state
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_baud_cnt;
    logic [CNT_W-1:0]   w_baud_next;
    logic [2:0]         r_bit_idx;
    logic [2:0]         w_bit_next;
    logic [7:0]         r_shift;
    logic [7:0]         w_shift_next;
    logic               r_tx_pin;
    logic               w_line;
    logic               w_baud_end;
    logic               w_can_pop;
`ifdef UART_TX_PARITY_EN
    logic               r_parity;
`endif

    // Full/empty come from the registered count only, so a write in the same
    // cycle as a pop from a full FIFO is still refused.
    assign w_full      = (r_count == COUNT_FULL);
    assign w_empty     = (r_count == '0);
    assign w_wr_accept = bus.tx_write && !w_full;
    assign w_baud_end  = (r_baud_cnt == BAUD_LAST);
    assign w_can_pop   = bus.en && !w_empty;

    // Byte storage: written on an accepted strobe; no reset needed because the
    // pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wptr] <= bus.tx_send_data;
        end
    end

    // FIFO pointers, occupancy count and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wptr <= r_wptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + FIFO_AW'(1);
            end
            case ({w_wr_accept, w_pop})
                2'b10:   r_count <= r_count + (FIFO_AW + 1)'(1);
                2'b01:   r_count <= r_count - (FIFO_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
            if (bus.tx_write && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Serialiser registers; a pop loads the head byte straight from the array
    // into the shift register (registered read of the storage).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx_pin   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_next;
            r_bit_idx  <= w_bit_next;
            r_tx_pin   <= w_line;
            if (w_pop) begin
                r_shift <= r_mem[r_rptr];
`ifdef UART_TX_PARITY_EN
                r_parity <= ^r_mem[r_rptr];
`endif
            end else begin
                r_shift <= w_shift_next;
            end
        end
    end

    // Next-state, baud/bit counting and line value for the current state.
    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud_cnt;
        w_bit_next   = r_bit_idx;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        w_line       = 1'b1;

        case (r_state)
            S_IDLE: begin
                w_line = 1'b1;
                if (w_can_pop) begin
                    w_pop        = 1'b1;
                    w_state_next = S_START;
                    w_baud_next  = '0;
                end
            end

            S_START: begin
                w_line = 1'b0;
                if (w_baud_end) begin
                    w_state_next = S_DATA;
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                end else begin
                    w_baud_next = r_baud_cnt + CNT_W'(1);
                end
            end

            S_DATA: begin
                w_line = r_shift[0];
                if (w_baud_end) begin
                    w_baud_next  = '0;
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end else begin
                        w_bit_next = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_baud_next = r_baud_cnt + CNT_W'(1);
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                w_line = r_parity;
                if (w_baud_end) begin
                    w_state_next = S_STOP;
                    w_baud_next  = '0;
                end else begin
                    w_baud_next = r_baud_cnt + CNT_W'(1);
                end
            end
`endif

            S_STOP: begin
                w_line = 1'b1;
                if (w_baud_end) begin
                    w_baud_next = '0;
                    // Chain straight into the next frame when more bytes wait.
                    if (w_can_pop) begin
                        w_pop        = 1'b1;
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    w_baud_next = r_baud_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_state_next = S_IDLE;
                w_baud_next  = '0;
            end
        endcase
    end

    assign bus.tx_pin_out      = r_tx_pin;
    assign bus.tx_buf_not_full = (r_count < COUNT_FULL);
    assign bus.tx_buf_empty    = w_empty;
    assign bus.tx_busy         = (r_state != S_IDLE);
    assign bus.tx_overflow     = r_overflow;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: scoreboard bench for uart_tx_buffered.
// The stimulus pushes every byte the FIFO should accept into exp_q; a monitor
// decodes frames from the serial pin and compares them with frames built
// from the queued bytes (start 0, data LSB-first, optional even parity, stop 1).
`timescale 1ns/1ps

module tb_uart_tx_buffered;

    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 100000;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int FIFO_AW  = 4;
    localparam int DEPTH    = 1 << FIFO_AW;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS    = 11;
`else
    localparam int NBITS    = 10;
`endif
    localparam int FRAME_CYC = NBITS * DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    uart_tx_buffered_if u_if();

    uart_tx_buffered #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .FIFO_AW  (FIFO_AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    int         frame_start[$];
    int         frames_done = 0;
    int         reset_epoch = 0;
    int         cycle = 0;

    always @(posedge clk) cycle <= cycle + 1;

    // Expected line pattern, slot i of the frame in bit i.
    function automatic logic [31:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {21'd0, 1'b1, ^b, b, 1'b0};
`else
        return {22'd0, 1'b1, b, 1'b0};
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] b, input bit push);
        @(negedge clk);
        u_if.tx_write     = 1'b1;
        u_if.tx_send_data = b;
        if (push) exp_q.push_back(b);
    endtask

    task automatic end_wr();
        @(negedge clk);
        u_if.tx_write = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("frames_seen", frames_done, target);
    endtask

    // Line must stay idle and the FSM parked for the given number of cycles.
    task automatic check_quiet(input string name, input int ncyc);
        int bad;
        bad = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (u_if.tx_pin_out !== 1'b1 || u_if.tx_busy !== 1'b0) bad++;
        end
        chk(name, bad, 0);
    endtask

    // Monitor: detect a start edge, sample each slot mid-bit, score the frame.
    initial begin : monitor
        logic        prev;
        logic [31:0] bits;
        logic [7:0]  eb;
        int          ep;
        int          st;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && u_if.tx_pin_out === 1'b0) begin
                st   = cycle;
                ep   = reset_epoch;
                bits = '0;
                for (int i = 0; i < NBITS; i++) begin
                    repeat ((i == 0) ? DIV / 2 : DIV) @(negedge clk);
                    bits[i] = u_if.tx_pin_out;
                end
                prev = u_if.tx_pin_out;
                if (ep != reset_epoch) begin
                    $display("frame at cycle %0d cut by reset, discarded", st);
                end else begin
                    frame_start.push_back(st);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame: got bits 0x%0h, expected no frame", bits);
                    end else begin
                        eb = exp_q.pop_front();
                        $display("frame @%0d: bits 0x%0h, expected byte 0x%02h (bits 0x%0h)",
                                 st, bits, eb, frame_of(eb));
                        chk("frame_bits", bits, frame_of(eb));
                    end
                    frames_done++;
                end
            end else begin
                prev = u_if.tx_pin_out;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int base;
        int n;
        u_if.en           = 1'b1;
        u_if.tx_write     = 1'b0;
        u_if.tx_send_data = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_pin",      u_if.tx_pin_out,      1'b1);
        chk("rst_empty",    u_if.tx_buf_empty,    1'b1);
        chk("rst_not_full", u_if.tx_buf_not_full, 1'b1);
        chk("rst_busy",     u_if.tx_busy,         1'b0);
        chk("rst_overflow", u_if.tx_overflow,     1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single byte 0x41: latency and frame length
        wr(8'h41, 1'b1);
        end_wr();
        chk("t1_empty_after_wr", u_if.tx_buf_empty, 1'b0);
        @(posedge clk); #1;
        chk("t1_pin_n1", u_if.tx_pin_out, 1'b1);
        chk("t1_busy_n1", u_if.tx_busy, 1'b1);
        @(posedge clk); #1;
        chk("t1_pin_n2", u_if.tx_pin_out, 1'b0);
        repeat (FRAME_CYC - 2) @(posedge clk);
        #1;
        chk("t1_busy_last", u_if.tx_busy, 1'b1);
        @(posedge clk); #1;
        chk("t1_busy_end", u_if.tx_busy, 1'b0);
        wait_frames(1, 200);

        // Back-to-back frames 0x55, 0xAA
        base = frames_done;
        wr(8'h55, 1'b1);
        wr(8'hAA, 1'b1);
        end_wr();
        wait_frames(base + 2, 3 * FRAME_CYC);
        chk("t2_empty", u_if.tx_buf_empty, 1'b1);
        chk("t2_gap", frame_start[base + 1] - frame_start[base], FRAME_CYC);

        // Fill with en=0, then overflow
        repeat (10) @(negedge clk);
        u_if.en = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wr(8'(i), 1'b1);
            if (i == DEPTH - 2) begin
                end_wr();
                chk("t3_not_full_15", u_if.tx_buf_not_full, 1'b1);
            end
        end
        end_wr();
        chk("t3_not_full_16", u_if.tx_buf_not_full, 1'b0);
        chk("t3_overflow_before", u_if.tx_overflow, 1'b0);
        chk("t3_busy_parked", u_if.tx_busy, 1'b0);
        wr(8'hFF, 1'b0);
        end_wr();
        chk("t3_overflow", u_if.tx_overflow, 1'b1);
        base = frames_done;
        u_if.en = 1'b1;
        wait_frames(base + DEPTH, (DEPTH + 1) * FRAME_CYC);
        repeat (10) @(negedge clk);
        chk("t3_drained", u_if.tx_buf_empty, 1'b1);

        // en dropped mid-frame with two bytes queued
        base = frames_done;
        wr(8'h33, 1'b1);
        wr(8'h11, 1'b1);
        wr(8'h22, 1'b1);
        end_wr();
        repeat (30) @(negedge clk);
        u_if.en = 1'b0;
        wait_frames(base + 1, 2 * FRAME_CYC);
        repeat (10) @(negedge clk);
        check_quiet("t4_parked", 300);
        chk("t4_empty", u_if.tx_buf_empty, 1'b0);
        chk("t4_not_full", u_if.tx_buf_not_full, 1'b1);
        u_if.en = 1'b1;
        wait_frames(base + 3, 3 * FRAME_CYC);

        // Reset during data bit 3 of 0x00, a second byte queued
        repeat (20) @(negedge clk);
        chk("t5_overflow_sticky", u_if.tx_overflow, 1'b1);
        wr(8'h00, 1'b0);
        wr(8'h99, 1'b0);
        end_wr();
        repeat (45) @(negedge clk);
        chk("t5_pin_bit3", u_if.tx_pin_out, 1'b0);
        #2;
        rst_n = 1'b0;
        reset_epoch++;
        #1;
        chk("t5_pin_async", u_if.tx_pin_out, 1'b1);
        chk("t5_empty", u_if.tx_buf_empty, 1'b1);
        chk("t5_busy", u_if.tx_busy, 1'b0);
        chk("t5_overflow", u_if.tx_overflow, 1'b0);
        chk("t5_not_full", u_if.tx_buf_not_full, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_quiet("t5_quiet_after_reset", 2 * FRAME_CYC);

`ifdef UART_TX_PARITY_EN
        // Parity frames: 0x07 -> parity 1, 0x03 -> parity 0
        base = frames_done;
        wr(8'h07, 1'b1);
        end_wr();
        wait_frames(base + 1, 2 * FRAME_CYC);
        wr(8'h03, 1'b1);
        end_wr();
        wait_frames(base + 2, 2 * FRAME_CYC);
`endif

        // Random bursts of up to four bytes, optional gaps between writes
        for (int r = 0; r < 10; r++) begin
            base = frames_done;
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                wr(8'($urandom_range(0, 255)), 1'b1);
                if ($urandom_range(0, 1) == 1) end_wr();
            end
            end_wr();
            wait_frames(base + n, (n + 1) * FRAME_CYC);
            repeat ($urandom_range(0, 15)) @(negedge clk);
        end

        // Any stray frame (e.g. the dropped 0xFF) would surface here
        repeat (2 * FRAME_CYC) @(negedge clk);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
